// File: rtl/sdram_check.sv
// sdram_check: self-checking SDRAM pattern tester.
// Fills 0..LAST_ADDR with addr[7:0]^key, reads the range back and compares
// every byte. Mismatches and read timeouts are counted. A "P/Fhhhh\r\n"
// line is sent over the UART byte port at the end of each pass.
// Optional build macro: SDRAM_CHECK_LOOP_EN. When defined, passes repeat
// forever and the key advances by one per pass. When undefined, the block
// parks in DONE until the next start pulse.
module sdram_check #(
    parameter int                   ADDR_BITS  = 25,
    parameter logic [ADDR_BITS-1:0] LAST_ADDR  = {ADDR_BITS{1'b1}},
    parameter logic [7:0]           SEED       = 8'h55,
    parameter int                   RD_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic [ADDR_BITS-1:0] sd_addr,
    output logic [7:0]           sd_wr_data,
    output logic                 sd_wr_enable,
    output logic                 sd_rd_enable,
    input  logic [7:0]           sd_rd_data,
    input  logic                 sd_rd_ready,
    input  logic                 sd_busy,
    output logic [7:0]           uart_data,
    output logic                 uart_strobe,
    input  logic                 uart_busy,
    output logic                 done,
    output logic                 pass,
    output logic [15:0]          err_count,
    output logic [ADDR_BITS-1:0] first_err_addr
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WRITE    = 3'd1,
        S_RD_ISSUE = 3'd2,
        S_RD_WAIT  = 3'd3,
        S_REPORT   = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    localparam logic [ADDR_BITS-1:0] ADDR_ZERO = {ADDR_BITS{1'b0}};
    localparam logic [ADDR_BITS-1:0] ADDR_ONE  = {{(ADDR_BITS-1){1'b0}}, 1'b1};
    // Timeout fires when the counter would reach RD_TIMEOUT, i.e. RD_TIMEOUT
    // cycles after the read request.
    localparam logic [15:0]          TMO_LAST  = 16'(RD_TIMEOUT - 1);
    localparam logic [2:0]           LAST_BYTE = 3'd6;

    // ASCII for one hex nibble, uppercase letters.
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        logic [7:0] c;
        if (nib < 4'd10) begin
            c = 8'h30 + {4'h0, nib};
        end else begin
            c = 8'h37 + {4'h0, nib};
        end
        return c;
    endfunction

    // Byte idx of the report line: verdict, four hex digits, CR, LF.
    function automatic logic [7:0] report_byte(input logic [2:0] idx, input logic [15:0] cnt);
        logic [7:0] b;
        case (idx)
            3'd0:    b = (cnt == 16'h0000) ? 8'h50 : 8'h46;
            3'd1:    b = hex_ascii(cnt[15:12]);
            3'd2:    b = hex_ascii(cnt[11:8]);
            3'd3:    b = hex_ascii(cnt[7:4]);
            3'd4:    b = hex_ascii(cnt[3:0]);
            3'd5:    b = 8'h0D;
            3'd6:    b = 8'h0A;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [7:0]             key_q, key_d;
    logic [15:0]            err_q, err_d;
    logic [ADDR_BITS-1:0]   first_q, first_d;
    logic [15:0]            tmo_q, tmo_d;
    logic [2:0]             idx_q, idx_d;
    logic                   req_prev_q, req_prev_d;
    logic                   strb_prev_q, strb_prev_d;

    logic                   wr_go;
    logic                   rd_go;
    logic                   tx_go;
    logic                   rd_hit;
    logic                   rd_tmo;
    logic                   bump_err;
    logic                   start_act;
    logic                   at_last;
    logic [7:0]             exp_byte;
    logic [7:0]             tx_byte;

    // Pattern byte for the current address and range-end flag.
    always_comb begin
        exp_byte = 8'(addr_q) ^ key_q;
        at_last  = (addr_q == LAST_ADDR);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q      <= ADDR_ZERO;
            key_q       <= SEED;
            err_q       <= 16'h0000;
            first_q     <= ADDR_ZERO;
            tmo_q       <= 16'h0000;
            idx_q       <= 3'd0;
            req_prev_q  <= 1'b0;
            strb_prev_q <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            key_q       <= key_d;
            err_q       <= err_d;
            first_q     <= first_d;
            tmo_q       <= tmo_d;
            idx_q       <= idx_d;
            req_prev_q  <= req_prev_d;
            strb_prev_q <= strb_prev_d;
        end
    end

    // Output decode: request/strobe permission and read-phase events.
    // Strobes are gated by the live busy inputs so no request ever lands
    // in a busy cycle, and by last cycle's strobe so they stay one cycle wide.
    always_comb begin
        wr_go   = 1'b0;
        rd_go   = 1'b0;
        tx_go   = 1'b0;
        rd_hit  = 1'b0;
        rd_tmo  = 1'b0;
        tx_byte = 8'h00;
        case (state_q)
            S_WRITE: begin
                if (!sd_busy && !req_prev_q) begin
                    wr_go = 1'b1;
                end else begin
                    wr_go = 1'b0;
                end
            end
            S_RD_ISSUE: begin
                if (!sd_busy && !req_prev_q) begin
                    rd_go = 1'b1;
                end else begin
                    rd_go = 1'b0;
                end
            end
            S_RD_WAIT: begin
                // A read completing on the timeout cycle still counts as a read.
                if (sd_rd_ready) begin
                    rd_hit = 1'b1;
                end else if (tmo_q == TMO_LAST) begin
                    rd_tmo = 1'b1;
                end else begin
                    rd_tmo = 1'b0;
                end
            end
            S_REPORT: begin
                tx_byte = report_byte(idx_q, err_q);
                if (!uart_busy && !strb_prev_q) begin
                    tx_go = 1'b1;
                end else begin
                    tx_go = 1'b0;
                end
            end
            default: begin
                wr_go = 1'b0;
            end
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WRITE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WRITE: begin
                if (wr_go && at_last) begin
                    state_d = S_RD_ISSUE;
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_RD_ISSUE: begin
                if (rd_go) begin
                    state_d = S_RD_WAIT;
                end else begin
                    state_d = S_RD_ISSUE;
                end
            end
            S_RD_WAIT: begin
                if ((rd_hit || rd_tmo) && at_last) begin
                    state_d = S_REPORT;
                end else if (rd_hit || rd_tmo) begin
                    state_d = S_RD_ISSUE;
                end else begin
                    state_d = S_RD_WAIT;
                end
            end
            S_REPORT: begin
                if (tx_go && (idx_q == LAST_BYTE)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_REPORT;
                end
            end
            S_DONE: begin
`ifdef SDRAM_CHECK_LOOP_EN
                state_d = S_WRITE;
`else
                if (start) begin
                    state_d = S_WRITE;
                end else begin
                    state_d = S_DONE;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath next values: address walk, error bookkeeping, timeout, report index.
    always_comb begin
        addr_d      = addr_q;
        key_d       = key_q;
        err_d       = err_q;
        first_d     = first_q;
        tmo_d       = tmo_q;
        idx_d       = idx_q;
        req_prev_d  = wr_go | rd_go;
        strb_prev_d = tx_go;
        bump_err    = rd_tmo | (rd_hit & (sd_rd_data != exp_byte));
`ifdef SDRAM_CHECK_LOOP_EN
        start_act   = (state_q == S_DONE) | ((state_q == S_IDLE) & start);
`else
        start_act   = ((state_q == S_DONE) | (state_q == S_IDLE)) & start;
`endif
        if (start_act) begin
            err_d   = 16'h0000;
            first_d = ADDR_ZERO;
            addr_d  = ADDR_ZERO;
            idx_d   = 3'd0;
        end else begin
            case (state_q)
                S_WRITE: begin
                    if (wr_go) begin
                        addr_d = at_last ? ADDR_ZERO : (addr_q + ADDR_ONE);
                    end else begin
                        addr_d = addr_q;
                    end
                end
                S_RD_ISSUE: begin
                    if (rd_go) begin
                        tmo_d = 16'h0000;
                    end else begin
                        tmo_d = tmo_q;
                    end
                end
                S_RD_WAIT: begin
                    tmo_d = tmo_q + 16'h0001;
                    if (bump_err) begin
                        if (err_q != 16'hFFFF) begin
                            err_d = err_q + 16'h0001;
                        end else begin
                            err_d = err_q;
                        end
                        if (err_q == 16'h0000) begin
                            first_d = addr_q;
                        end else begin
                            first_d = first_q;
                        end
                    end else begin
                        err_d = err_q;
                    end
                    if ((rd_hit || rd_tmo) && !at_last) begin
                        addr_d = addr_q + ADDR_ONE;
                        idx_d  = 3'd0;
                    end else if (rd_hit || rd_tmo) begin
                        addr_d = addr_q;
                        idx_d  = 3'd0;
                    end else begin
                        addr_d = addr_q;
                    end
                end
                S_REPORT: begin
                    if (tx_go) begin
                        idx_d = idx_q + 3'd1;
`ifdef SDRAM_CHECK_LOOP_EN
                        if (idx_q == LAST_BYTE) begin
                            key_d = key_q + 8'd1;
                        end else begin
                            key_d = key_q;
                        end
`endif
                    end else begin
                        idx_d = idx_q;
                    end
                end
                default: begin
                    addr_d = addr_q;
                end
            endcase
        end
    end

    // Port drive. Data buses are zero outside the phase that uses them.
    always_comb begin
        sd_addr        = addr_q;
        sd_wr_data     = (state_q == S_WRITE) ? exp_byte : 8'h00;
        sd_wr_enable   = wr_go;
        sd_rd_enable   = rd_go;
        uart_data      = tx_byte;
        uart_strobe    = tx_go;
        done           = (state_q == S_DONE);
        pass           = (state_q == S_DONE) && (err_q == 16'h0000);
        err_count      = err_q;
        first_err_addr = first_q;
    end

endmodule

// File: tb/tb_sdram_check.sv
// Directed-plus-random bench for sdram_check (default build, loop disabled).
// A behavioural SDRAM/UART model drives the handshakes; the expected result
// of each pass is derived from the corruption table with plain arithmetic.
module tb_sdram_check;

    localparam int AB  = 4;
    localparam int N   = 16;
    localparam int TMO = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AB-1:0] sd_addr;
    logic [7:0]    sd_wr_data;
    logic          sd_wr_enable;
    logic          sd_rd_enable;
    logic [7:0]    sd_rd_data;
    logic          sd_rd_ready;
    logic          sd_busy;
    logic [7:0]    uart_data;
    logic          uart_strobe;
    logic          uart_busy;
    logic          done;
    logic          pass;
    logic [15:0]   err_count;
    logic [AB-1:0] first_err_addr;

    always #5 clk = ~clk;

    sdram_check #(
        .ADDR_BITS (AB),
        .LAST_ADDR (4'hF),
        .SEED      (8'h55),
        .RD_TIMEOUT(TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .sd_addr       (sd_addr),
        .sd_wr_data    (sd_wr_data),
        .sd_wr_enable  (sd_wr_enable),
        .sd_rd_enable  (sd_rd_enable),
        .sd_rd_data    (sd_rd_data),
        .sd_rd_ready   (sd_rd_ready),
        .sd_busy       (sd_busy),
        .uart_data     (uart_data),
        .uart_strobe   (uart_strobe),
        .uart_busy     (uart_busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .first_err_addr(first_err_addr)
    );

    int compared   = 0;
    int mismatched = 0;
    int viol       = 0;

    logic [7:0]    mem         [N];
    bit            corrupt_en  [N];
    logic [7:0]    corrupt_val [N];
    bit            drop        [N];
    logic [AB-1:0] wr_addr_q [$];
    logic [7:0]    wr_data_q [$];
    logic [AB-1:0] rd_addr_q [$];
    logic [7:0]    tx_q      [$];
    int            ub_len         = 1;
    int            hold_busy_addr = -1;
    bit            uart_hold      = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // SDRAM + UART model and protocol monitor. Outputs are observed at the
    // falling edge (what the DUT commits at the next rising edge); model
    // inputs change just after the rising edge.
    initial begin : model
        int            bcnt;
        int            fcnt;
        int            pcnt;
        int            ucnt;
        logic [AB-1:0] pend;
        bit            req;
        bit            rd_now;
        bit            tx_now;
        bit            prev_req;
        bit            prev_tx;
        bcnt = 0; fcnt = 0; pcnt = 0; ucnt = 0; pend = '0;
        prev_req = 1'b0; prev_tx = 1'b0;
        sd_busy = 1'b0; sd_rd_ready = 1'b0; sd_rd_data = 8'h00; uart_busy = 1'b0;
        for (int a = 0; a < N; a++) mem[a] = 8'h00;
        forever begin
            @(negedge clk);
            req    = sd_wr_enable || sd_rd_enable;
            rd_now = sd_rd_enable;
            tx_now = uart_strobe;
            if (req && sd_busy) viol++;
            if (req && prev_req) viol++;
            if (sd_wr_enable && sd_rd_enable) viol++;
            if (tx_now && uart_busy) viol++;
            if (tx_now && prev_tx) viol++;
            if (sd_wr_enable) begin
                wr_addr_q.push_back(sd_addr);
                wr_data_q.push_back(sd_wr_data);
                mem[sd_addr] = sd_wr_data;
                if (hold_busy_addr == int'(sd_addr)) begin
                    fcnt = 20;
                    hold_busy_addr = -1;
                end
            end
            if (rd_now) begin
                rd_addr_q.push_back(sd_addr);
                pend = sd_addr;
            end
            if (tx_now) tx_q.push_back(uart_data);
            prev_req = req;
            prev_tx  = tx_now;
            @(posedge clk);
            #1;
            if (req) bcnt = 3;
            if (rd_now) pcnt = 4;
            sd_busy = (bcnt > 0) || (fcnt > 0);
            if (bcnt > 0) bcnt--;
            if (fcnt > 0) fcnt--;
            sd_rd_ready = 1'b0;
            sd_rd_data  = 8'($urandom);
            if (pcnt > 0) begin
                pcnt--;
                if (pcnt == 0 && !drop[pend]) begin
                    sd_rd_ready = 1'b1;
                    sd_rd_data  = corrupt_en[pend] ? corrupt_val[pend] : mem[pend];
                end
            end
            if (tx_now) begin
                if (uart_hold && tx_q.size() == 2) begin
                    ucnt = 50;
                    uart_hold = 1'b0;
                end else begin
                    ucnt = ub_len;
                end
            end
            uart_busy = (ucnt > 0);
            if (ucnt > 0) ucnt--;
        end
    end

    task automatic clear_faults();
        for (int a = 0; a < N; a++) begin
            corrupt_en[a]  = 1'b0;
            corrupt_val[a] = 8'h00;
            drop[a]        = 1'b0;
        end
    endtask

    // Reference: an address is an error if its read never returns or returns
    // a byte other than addr ^ 0x55.
    task automatic expect_pass(output int errs, output int first);
        bit bad;
        errs = 0;
        first = 0;
        for (int a = 0; a < N; a++) begin
            bad = drop[a] || (corrupt_en[a] && (corrupt_val[a] != (8'(a) ^ 8'h55)));
            if (bad) begin
                if (errs == 0) first = a;
                errs++;
            end
        end
    endtask

    task automatic run_pass(input string tag, input bit poke_write, input bit poke_report);
        int    errs;
        int    first;
        int    bad;
        string line;
        bit    poked;
        expect_pass(errs, first);
        line = $sformatf("%s%04X\r\n", (errs == 0) ? "P" : "F", errs);
        wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete(); tx_q.delete();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        poked = 1'b0;
        for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (!poked && poke_write && wr_addr_q.size() == 6) begin
                start = 1'b1;
                poked = 1'b1;
            end
            if (!poked && poke_report && tx_q.size() == 3) begin
                start = 1'b1;
                poked = 1'b1;
            end
        end
        start = 1'b0;
        check({tag, ":done"}, 32'(done), 32'd1);
        check({tag, ":pass"}, 32'(pass), 32'(errs == 0));
        check({tag, ":err_count"}, 32'(err_count), 32'(errs));
        check({tag, ":first_err_addr"}, 32'(first_err_addr), 32'(first));
        check({tag, ":writes"}, 32'(wr_addr_q.size()), 32'(N));
        check({tag, ":reads"}, 32'(rd_addr_q.size()), 32'(N));
        bad = 0;
        for (int i = 0; i < wr_addr_q.size(); i++) begin
            if (wr_addr_q[i] != AB'(i) || wr_data_q[i] != (8'(i) ^ 8'h55)) bad++;
            if (i < rd_addr_q.size() && rd_addr_q[i] != AB'(i)) bad++;
        end
        check({tag, ":addr_data_order"}, 32'(bad), 32'd0);
        check({tag, ":tx_len"}, 32'(tx_q.size()), 32'd7);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("%s:tx_byte%0d", tag, i),
                  (i < tx_q.size()) ? 32'(tx_q[i]) : 32'hDEAD, 32'(line[i]));
        end
        check({tag, ":protocol"}, 32'(viol), 32'd0);
    endtask

    initial begin : stim
        int errs;
        int first;
        int wcount;
        reset = 1'b1;
        start = 1'b0;
        clear_faults();
        repeat (3) @(posedge clk);
        #1;
        check("rst:done", 32'(done), 32'd0);
        check("rst:pass", 32'(pass), 32'd0);
        check("rst:err_count", 32'(err_count), 32'd0);
        check("rst:first_err_addr", 32'(first_err_addr), 32'd0);
        check("rst:sd_addr", 32'(sd_addr), 32'd0);
        check("rst:sd_wr_data", 32'(sd_wr_data), 32'd0);
        check("rst:uart_data", 32'(uart_data), 32'd0);
        check("rst:strobes", 32'({sd_wr_enable, sd_rd_enable, uart_strobe}), 32'd0);
        reset = 1'b0;

        // Clean pass; DONE must then hold with no further traffic.
        ub_len = int'($urandom_range(0, 3));
        run_pass("clean", 1'b0, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        check("done_hold", 32'(done), 32'd1);
        check("done_quiet", 32'(tx_q.size() + wr_addr_q.size()), 32'd23);

        // Corrupt 5 and 9; start pulse during WRITE must be ignored.
        clear_faults();
        corrupt_en[5] = 1'b1; corrupt_val[5] = 8'h00;
        corrupt_en[9] = 1'b1; corrupt_val[9] = 8'h5C ^ 8'($urandom_range(1, 255));
        run_pass("corrupt59", 1'b1, 1'b0);

        // Address 3 never completes: one timeout error.
        clear_faults();
        drop[3] = 1'b1;
        run_pass("timeout3", 1'b0, 1'b0);

        // Random faults, plus a long busy hold mid-WRITE and a long UART
        // stall with a stray start during REPORT.
        for (int k = 0; k < 3; k++) begin
            clear_faults();
            for (int a = 0; a < N; a++) begin
                if ($urandom_range(0, 3) == 0) begin
                    corrupt_en[a]  = 1'b1;
                    corrupt_val[a] = 8'($urandom);
                end
                if ($urandom_range(0, 9) == 0) drop[a] = 1'b1;
            end
            ub_len         = int'($urandom_range(0, 3));
            hold_busy_addr = (k == 0) ? 7 : -1;
            uart_hold      = (k == 1);
            run_pass($sformatf("rand%0d", k), 1'b0, (k == 1));
        end

        // Reset while waiting on the read of address 6.
        clear_faults();
        corrupt_en[2] = 1'b1; corrupt_val[2] = 8'hFF;
        wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete(); tx_q.delete();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int cyc = 0; cyc < 2000 && rd_addr_q.size() < 7; cyc++) begin
            @(posedge clk);
            #1;
        end
        check("midrst:reached_rd6", 32'(rd_addr_q.size()), 32'd7);
        check("midrst:err_before", 32'(err_count), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst:done", 32'(done), 32'd0);
        check("midrst:err_count", 32'(err_count), 32'd0);
        check("midrst:first_err_addr", 32'(first_err_addr), 32'd0);
        check("midrst:strobes", 32'({sd_wr_enable, sd_rd_enable, uart_strobe}), 32'd0);
        reset = 1'b0;
        wcount = wr_addr_q.size();
        repeat (10) @(posedge clk);
        #1;
        check("midrst:idle_err", 32'(err_count), 32'd0);
        check("midrst:idle_quiet", 32'(wr_addr_q.size() + tx_q.size()), 32'(wcount));
        clear_faults();
        expect_pass(errs, first);
        check("midrst:ref_clean", 32'(errs), 32'd0);
        run_pass("after_reset", 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
